// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM states, access sizes and owners.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Bus wait timer: counts cycles without ack and flags the cycle that reaches TIMEOUT.
module arb_wait_timer #(
    parameter int SW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [SW-1:0] LP_LIMIT = SW'(TIMEOUT);

    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cntNext;

    assign w_cntNext = r_cnt + 1'b1;
    // Expiry is flagged in the cycle whose increment would land on TIMEOUT.
    assign o_expired = i_en && (w_cntNext == LP_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cntNext;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch (IF) and load/store (MEM).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int SW           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LP_STARVE = CW'(STARVE_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_nextState;
    arb_owner_t    r_owner;
    logic [CW-1:0] r_starveCnt;
    logic          w_inBus;
    logic          w_arbitrate;
    logic          w_expired;
    logic          w_finish;
    logic          w_ifReqM;
    logic          w_memReqM;
    logic          w_grantIf;
    logic          w_grantMem;

    arb_wait_timer #(
        .SW      (SW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_grantIf | w_grantMem),
        .i_en      (w_inBus & ~bus_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_grantMem)     w_nextState = BUS_MEM;
                else if (w_grantIf) w_nextState = BUS_IF;
                else                w_nextState = IDLE;
            end
            BUS_IF, BUS_MEM: begin
                if (w_finish) w_nextState = DONE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // In DONE the requester just served is masked so the other side gets the bus at once.
    always_comb begin
        w_inBus     = (r_state == BUS_IF) || (r_state == BUS_MEM);
        w_arbitrate = (r_state == IDLE) || (r_state == DONE);
        w_finish    = w_inBus && (bus_ack || w_expired);
        w_ifReqM    = if_req  && !((r_state == DONE) && (r_owner == OWN_IF));
        w_memReqM   = mem_req && !((r_state == DONE) && (r_owner == OWN_MEM));
        w_grantMem  = w_arbitrate && w_memReqM && !(w_ifReqM && (r_starveCnt == LP_STARVE));
        w_grantIf   = w_arbitrate && w_ifReqM && !w_grantMem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starveCnt <= '0;
        end else if (w_grantIf) begin
            r_starveCnt <= '0;
        end else if (w_grantMem && if_req && (r_starveCnt != LP_STARVE)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= OWN_IF;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            bus_err   <= 1'b0;
            if (w_grantMem) begin
                r_owner   <= OWN_MEM;
                bus_req   <= 1'b1;
                bus_we    <= mem_we;
                bus_size  <= mem_size;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
            end else if (w_grantIf) begin
                r_owner  <= OWN_IF;
                bus_req  <= 1'b1;
                bus_we   <= 1'b0;
                bus_size <= SZ_WORD;
                bus_addr <= if_addr;
            end else if (w_finish) begin
                bus_req <= 1'b0;
                bus_err <= ~bus_ack;
                if (r_owner == OWN_IF) begin
                    if_valid <= 1'b1;
                    if_rdata <= bus_ack ? bus_rdata : 32'd0;
                end else begin
                    mem_valid <= 1'b1;
                    if (!bus_ack) begin
                        mem_rdata <= 32'd0;
                    end else if (!bus_we) begin
                        mem_rdata <= bus_rdata;
                    end
                end
            end
        end
    end

    assign if_stall  = if_req  & ~if_valid;
    assign mem_stall = mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs are sampled on falling edges.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (255),
        .SW           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_stall (mem_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_size  (bus_size),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic mReq, input logic mWe, input logic [1:0] mSize,
                                 input logic [31:0] mAddr, input logic [31:0] mWdata);
        if_req    = iReq;
        if_addr   = iAddr;
        mem_req   = mReq;
        mem_we    = mWe;
        mem_size  = mSize;
        mem_addr  = mAddr;
        mem_wdata = mWdata;
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst_bus_req",  32'(bus_req),   32'd0);
        checkOutput("rst_bus_addr", bus_addr,       32'd0);
        checkOutput("rst_if_valid", 32'(if_valid),  32'd0);
        checkOutput("rst_mem_valid",32'(mem_valid), 32'd0);
        checkOutput("rst_bus_err",  32'(bus_err),   32'd0);
        checkOutput("rst_if_rdata", if_rdata,       32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Stray ack with nobody requesting
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("idle_ack_if_valid",  32'(if_valid),  32'd0);
        checkOutput("idle_ack_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("idle_ack_bus_req",   32'(bus_req),   32'd0);
        bus_ack = 1'b0;

        // IF alone, ack in first bus cycle
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        #1 checkOutput("t1_if_stall_c0", 32'(if_stall), 32'd1);
        @(negedge clk);
        checkOutput("t1_bus_req",  32'(bus_req),  32'd1);
        checkOutput("t1_bus_addr", bus_addr,      32'h40);
        checkOutput("t1_bus_we",   32'(bus_we),   32'd0);
        checkOutput("t1_bus_size", 32'(bus_size), 32'd2);
        checkOutput("t1_if_stall_c1", 32'(if_stall), 32'd1);
        checkOutput("t1_if_valid_c1", 32'(if_valid), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
        @(negedge clk);
        checkOutput("t1_if_valid",  32'(if_valid), 32'd1);
        checkOutput("t1_if_rdata",  if_rdata,      32'h0050_0093);
        checkOutput("t1_if_stall_c2", 32'(if_stall), 32'd0);
        checkOutput("t1_bus_req_drop", 32'(bus_req), 32'd0);
        bus_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checkOutput("t1_if_valid_once", 32'(if_valid), 32'd0);

        // Both at once: MEM load first, IF granted at the DONE edge
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
        @(negedge clk);
        checkOutput("t2_mem_wins_addr", bus_addr, 32'h100);
        checkOutput("t2_bus_we",        32'(bus_we), 32'd0);
        checkOutput("t2_if_stall",      32'(if_stall), 32'd1);
        repeat (2) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("t2_mem_valid",    32'(mem_valid), 32'd1);
        checkOutput("t2_mem_rdata",    mem_rdata,      32'hDEAD_BEEF);
        checkOutput("t2_if_valid_lo",  32'(if_valid),  32'd0);
        checkOutput("t2_mem_stall",    32'(mem_stall), 32'd0);
        bus_ack = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        checkOutput("t2_if_granted",   32'(bus_req), 32'd1);
        checkOutput("t2_if_addr",      bus_addr,     32'h44);
        checkOutput("t2_mem_valid_lo", 32'(mem_valid), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        checkOutput("t2_if_valid",  32'(if_valid), 32'd1);
        checkOutput("t2_if_rdata",  if_rdata,      32'h1111_1111);
        bus_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Byte store: mem_rdata keeps the previous load value
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 2'b00, 32'h203, 32'hAB);
        @(negedge clk);
        checkOutput("st_bus_we",    32'(bus_we),   32'd1);
        checkOutput("st_bus_size",  32'(bus_size), 32'd0);
        checkOutput("st_bus_addr",  bus_addr,      32'h203);
        checkOutput("st_bus_wdata", bus_wdata,     32'hAB);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("st_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("st_mem_rdata", mem_rdata,      32'hDEAD_BEEF);
        bus_ack = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        checkOutput("st_mem_valid_once", 32'(mem_valid), 32'd0);

        // Four MEM wins over a waiting IF, then IF must win
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 2'b10, 32'h400 + 32'(k * 4), 32'd0);
            @(negedge clk);
            checkOutput("sv_mem_grant", bus_addr, 32'h400 + 32'(k * 4));
            if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'(k);
            @(negedge clk);
            checkOutput("sv_mem_valid", 32'(mem_valid), 32'd1);
            bus_ack = 1'b0; mem_req = 1'b0;
            @(negedge clk);
        end
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 2'b10, 32'h500, 32'd0);
        @(negedge clk);
        checkOutput("sv_if_wins_addr", bus_addr, 32'h80);
        checkOutput("sv_if_wins_we",   32'(bus_we), 32'd0);
        mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        @(negedge clk);
        checkOutput("sv_if_valid", 32'(if_valid), 32'd1);
        bus_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 2'b10, 32'h600, 32'd0);
        @(negedge clk);
        checkOutput("sv_cnt_cleared_mem_wins", bus_addr, 32'h600);
        if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
        @(negedge clk);
        checkOutput("sv_mem_valid_after", 32'(mem_valid), 32'd1);
        bus_ack = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        // Fetch with no ack ever: aborts after 255 bus cycles
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        n = 0;
        while (bus_req && n < 400) begin
            n++;
            @(negedge clk);
        end
        checkOutput("to_bus_req_cycles", 32'(n), 32'd255);
        checkOutput("to_bus_err",   32'(bus_err),  32'd1);
        checkOutput("to_if_valid",  32'(if_valid), 32'd1);
        checkOutput("to_if_rdata",  if_rdata,      32'd0);
        checkOutput("to_bus_req",   32'(bus_req),  32'd0);
        if_req = 1'b0;
        @(negedge clk);
        checkOutput("to_bus_err_once", 32'(bus_err), 32'd0);

        // Reset in the middle of a load, then restart
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'h300, 32'd0);
        @(negedge clk);
        checkOutput("rs_bus_req_before", 32'(bus_req), 32'd1);
        #2 reset = 1'b0;
        #1 checkOutput("rs_bus_req_async", 32'(bus_req), 32'd0);
        checkOutput("rs_bus_addr_async", bus_addr, 32'd0);
        @(negedge clk);
        checkOutput("rs_no_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rs_mem_stall",    32'(mem_stall), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rs_restart_req",  32'(bus_req), 32'd1);
        checkOutput("rs_restart_addr", bus_addr,     32'h300);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("rs_mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("rs_mem_rdata", mem_rdata,      32'hCAFE_F00D);
        bus_ack = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the instruction-fetch stage (IF) and the load/store stage (MEM) of the 5-stage pipelined core.
- Sequences each bus transaction with a small FSM and returns data or a completion pulse to the winning requester.
- Drives per-requester stall lines that feed the pipeline-register enables, in the same role as the existing busy signal.
- Replaces the separate instruction/data memories when the core moves to a unified memory.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF is waiting; once reached, IF wins the next arbitration.
- TIMEOUT, 255: bus cycles to wait for bus_ack before the transaction is aborted.
- SW, 8: width of the timeout counter; must satisfy 2^SW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level; held until if_valid
- if_addr  in  32  fetch address (word access)
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle completion pulse to IF
- if_stall  out  1  IF stage must hold
- mem_req  in  1  load/store request, level; held until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_valid  out  1  one-cycle completion pulse to MEM
- mem_stall  out  1  MEM stage and all older stages must hold
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write enable
- bus_size  out  2  bus access size
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_ack  in  1  bus completes the transaction this cycle
- bus_err  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE and both counters clear.
  - All registered outputs go to 0: bus_req, bus_we, bus_size, bus_addr, bus_wdata, if_rdata, mem_rdata, if_valid, mem_valid, bus_err.
  - bus_req drops immediately, even mid-transaction. An aborted transaction produces no valid pulse.
- FSM states:
  - IDLE: arbitrate.
  - BUS_IF: fetch in flight.
  - BUS_MEM: load/store in flight.
  - DONE: one cycle; the valid pulse is high.
- Arbitration in IDLE:
  - Only MEM requesting -> MEM wins.
  - Only IF requesting -> IF wins.
  - Both requesting -> MEM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - No request -> stay in IDLE.
- Starvation counter (starve_cnt):
  - Increments on a MEM grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
- On a grant, the bus outputs are registered at that edge and held constant until the transaction leaves BUS_*:
  - IF grant: bus_we=0, bus_size=10.
  - MEM grant: bus_we, bus_size, bus_addr and bus_wdata come from the mem_* inputs.
- In BUS_*, with bus_ack=1:
  - bus_req drops at the next edge.
  - For a read, bus_rdata is captured into the winner's rdata. A store leaves mem_rdata unchanged.
  - The winner's valid goes to 1 for exactly one cycle; the FSM moves to DONE.
- Latency:
  - Minimum is 2 cycles from request to valid: grant edge, then ack in the first bus_req cycle, then valid.
  - Otherwise latency = 1 + ack delay + 1.
- Timeout:
  - The wait counter clears on entry to BUS_* and increments on each cycle without ack.
  - When it reaches TIMEOUT: bus_req drops, the winner's rdata is set to 0, valid and bus_err pulse together, and the FSM moves to DONE.
- DONE:
  - The completing requester's req is masked for arbitration in this cycle.
  - The other requester's req may be granted at the DONE->IDLE edge: DONE arbitrates like IDLE with the mask applied.
  - This gives back-to-back transactions with no dead bus cycle beyond the ack cycle.
- Stall outputs are combinational:
  - if_stall = if_req & ~if_valid
  - mem_stall = mem_req & ~mem_valid
- A bus_ack seen in IDLE or DONE is ignored.
- Requester inputs that change mid-transaction have no effect until the next grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state encoding (IDLE, BUS_IF, BUS_MEM, DONE).
  - Size constants SZ_BYTE, SZ_HALF, SZ_WORD.
  - Owner encoding OWN_IF, OWN_MEM.
- Sub-module arb_wait_timer: SW-bit counter with clear, enable and an expired output compared against TIMEOUT. The starvation counter stays inline.

Test Plan:
- IF only, if_addr=0x40, bus_ack on the first bus_req cycle with bus_rdata=0x00500093 -> if_valid exactly 2 cycles after if_req, if_rdata=0x00500093, if_stall high for 2 cycles.
- if_req and mem_req rise together, load from 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> MEM served first with mem_rdata=0xDEADBEEF; IF granted at the DONE edge; bus_addr switches to the IF address.
- mem_req held with a new load each completion while if_req stays high -> after 4 MEM grants the 5th grant goes to IF; starve_cnt then returns to 0.
- Store: mem_we=1, size=00, addr=0x203, wdata=0xAB -> bus_we=1, bus_size=00, bus_addr=0x203; mem_rdata unchanged; mem_valid pulses once.
- IF request with bus_ack never asserted, TIMEOUT=255 -> after 255 bus_req cycles: bus_err and if_valid pulse together, if_rdata=0, bus_req=0.
- reset driven low mid BUS_MEM -> bus_req=0 asynchronously, no mem_valid pulse; after reset release with mem_req still high, the transaction restarts from IDLE.
